// File: rtl/face_det_pkg.sv
// Shared widths, default frame geometry and pixel/coordinate types for the face detection front end.
package face_det_pkg;
  localparam int DATA_WIDTH_8    = 8;
  localparam int DATA_WIDTH_12   = 12;
  localparam int DATA_WIDTH_16   = 16;
  localparam int DEF_ORI_WIDTH   = 800;
  localparam int DEF_ORI_HEIGHT  = 600;
  localparam int DEF_COORD_WIDTH = 12;
  localparam int DEF_SCALE       = 2;
  localparam int INTEGRAL_LENGTH = 24;

  typedef logic [DEF_COORD_WIDTH-1:0] coord_t;
  typedef logic [DATA_WIDTH_12-1:0]   pixel_t;
endpackage

// File: rtl/frame_xy_counter.sv
// Raster x/y counter wrapping at W_MAX-1 / H_MAX-1; load0 makes the current step count from (0,0).
// Registered state, no latency on flags; advances only on en, never stalls upstream.
module frame_xy_counter #(
  parameter int W_MAX       = 800,
  parameter int H_MAX       = 600,
  parameter int COORD_WIDTH = 12
) (
  input  logic                   clk_os,
  input  logic                   reset_fpga,
  input  logic                   en,
  input  logic                   load0,
  output logic [COORD_WIDTH-1:0] x,
  output logic [COORD_WIDTH-1:0] y,
  output logic                   at_origin,
  output logic                   at_last
);
  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(W_MAX - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(H_MAX - 1);
  localparam logic [COORD_WIDTH-1:0] ONE    = COORD_WIDTH'(1);

  logic [COORD_WIDTH-1:0] base_x;
  logic [COORD_WIDTH-1:0] base_y;

  // a resync treats the current pixel as the origin, so stepping starts from zero
  assign base_x    = load0 ? '0 : x;
  assign base_y    = load0 ? '0 : y;
  assign at_origin = (x == '0) && (y == '0);
  assign at_last   = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk_os or posedge reset_fpga) begin
    if (reset_fpga) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (base_x == X_LAST) begin
        x <= '0;
        y <= (base_y == Y_LAST) ? '0 : base_y + ONE;
      end else begin
        x <= base_x + ONE;
        y <= base_y;
      end
    end
  end
endmodule

// File: rtl/frame_coord_sequencer.sv
// Pixel-stream coordinate tracker and SCALE decimator; optional resync on i_sof under FRAME_SYNC_CHECK_EN.
// 1-cycle registered latency; no backpressure, gaps in i_valid simply freeze all counters.
module frame_coord_sequencer
  import face_det_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_12,
  parameter int COORD_WIDTH = DEF_COORD_WIDTH,
  parameter int ORI_WIDTH   = DEF_ORI_WIDTH,
  parameter int ORI_HEIGHT  = DEF_ORI_HEIGHT,
  parameter int SCALE       = DEF_SCALE,
  parameter int WIN_LEN     = INTEGRAL_LENGTH
) (
  input  logic                   clk_os,
  input  logic                   reset_fpga,
  input  logic                   i_valid,
  input  logic                   i_sof,
  input  logic [DATA_WIDTH-1:0]  i_pixel,
  output logic                   o_valid,
  output logic [DATA_WIDTH-1:0]  o_pixel,
  output logic [COORD_WIDTH-1:0] o_ori_x,
  output logic [COORD_WIDTH-1:0] o_ori_y,
  output logic [COORD_WIDTH-1:0] o_scale_x,
  output logic [COORD_WIDTH-1:0] o_scale_y,
  output logic                   o_window,
  output logic                   o_sof,
  output logic                   o_eof,
  output logic                   o_sync_err,
  output logic [7:0]             o_err_cnt
);
  localparam int RES_W = ORI_WIDTH / SCALE;
  localparam int RES_H = ORI_HEIGHT / SCALE;
  localparam int PW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [PW-1:0]          PH_LAST    = PW'(SCALE - 1);
  localparam logic [PW-1:0]          PH_ONE     = PW'(1);
  localparam logic [COORD_WIDTH-1:0] ORI_X_LAST = COORD_WIDTH'(ORI_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] WIN_MIN    = COORD_WIDTH'(WIN_LEN - 1);
  localparam bit                     RES_1X1    = (RES_W == 1) && (RES_H == 1);

  if ((ORI_WIDTH > (1 << COORD_WIDTH)) || (ORI_HEIGHT > (1 << COORD_WIDTH))) begin : g_coord_too_narrow
    $error("COORD_WIDTH cannot hold ORI_WIDTH-1 / ORI_HEIGHT-1");
  end

  logic [COORD_WIDTH-1:0] ori_x, ori_y, sc_x, sc_y;
  logic [COORD_WIDTH-1:0] cur_ori_x, cur_ori_y, cur_sc_x, cur_sc_y;
  logic                   ori_at_origin, ori_last_unused, sc_at_origin, sc_at_last;
  logic [PW-1:0]          phase_x, phase_y, px_base, py_base;
  logic                   resync, kept, ori_x_wrap;

  assign px_base    = resync ? '0 : phase_x;
  assign py_base    = resync ? '0 : phase_y;
  assign cur_ori_x  = resync ? '0 : ori_x;
  assign cur_ori_y  = resync ? '0 : ori_y;
  assign cur_sc_x   = resync ? '0 : sc_x;
  assign cur_sc_y   = resync ? '0 : sc_y;
  assign ori_x_wrap = (cur_ori_x == ORI_X_LAST);
  assign kept       = i_valid && (px_base == '0) && (py_base == '0);

  frame_xy_counter #(.W_MAX(ORI_WIDTH), .H_MAX(ORI_HEIGHT), .COORD_WIDTH(COORD_WIDTH)) u_ori_cnt (
    .clk_os(clk_os), .reset_fpga(reset_fpga), .en(i_valid), .load0(resync),
    .x(ori_x), .y(ori_y), .at_origin(ori_at_origin), .at_last(ori_last_unused)
  );

  frame_xy_counter #(.W_MAX(RES_W), .H_MAX(RES_H), .COORD_WIDTH(COORD_WIDTH)) u_res_cnt (
    .clk_os(clk_os), .reset_fpga(reset_fpga), .en(kept), .load0(resync),
    .x(sc_x), .y(sc_y), .at_origin(sc_at_origin), .at_last(sc_at_last)
  );

  // frame dimensions are multiples of SCALE, so phase wrap lines up with the line/frame wrap
  always_ff @(posedge clk_os or posedge reset_fpga) begin
    if (reset_fpga) begin
      phase_x <= '0;
      phase_y <= '0;
    end else if (i_valid) begin
      phase_x <= (px_base == PH_LAST) ? '0 : px_base + PH_ONE;
      if (ori_x_wrap) phase_y <= (py_base == PH_LAST) ? '0 : py_base + PH_ONE;
      else            phase_y <= py_base;
    end
  end

  always_ff @(posedge clk_os or posedge reset_fpga) begin
    if (reset_fpga) begin
      o_valid   <= 1'b0;
      o_window  <= 1'b0;
      o_sof     <= 1'b0;
      o_eof     <= 1'b0;
      o_pixel   <= '0;
      o_ori_x   <= '0;
      o_ori_y   <= '0;
      o_scale_x <= '0;
      o_scale_y <= '0;
    end else begin
      o_valid  <= kept;
      o_window <= kept && (cur_sc_x >= WIN_MIN) && (cur_sc_y >= WIN_MIN);
      o_sof    <= kept && (resync || sc_at_origin);
      o_eof    <= kept && (resync ? RES_1X1 : sc_at_last);
      if (kept) begin
        o_pixel   <= i_pixel;
        o_ori_x   <= cur_ori_x;
        o_ori_y   <= cur_ori_y;
        o_scale_x <= cur_sc_x;
        o_scale_y <= cur_sc_y;
      end
    end
  end

`ifdef FRAME_SYNC_CHECK_EN
  assign resync = i_valid && i_sof && !ori_at_origin;

  always_ff @(posedge clk_os or posedge reset_fpga) begin
    if (reset_fpga) begin
      o_sync_err <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      o_sync_err <= resync;
      if (resync && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end
`else
  logic unused_sync;
  assign resync      = 1'b0;
  assign o_sync_err  = 1'b0;
  assign o_err_cnt   = '0;
  assign unused_sync = ^{i_sof, ori_at_origin};
`endif
endmodule
